// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared definitions for the data-memory responder.
// Holds the FSM state encoding, the default latency constants and the
// helper that sizes the wait-state counter.
package dmem_resp_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_ADDR_BITS  = 12;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_WR_LATENCY = 1;

  // IDLE waits for a strobe, BUSY burns wait states, DONE is the
  // single completion cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter is loaded with LAT-1 at most, so clog2 of the larger
  // latency is enough; keep at least one bit so the vector is legal.
  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (max_lat <= 1) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// dmem_resp_ram: single-port word RAM with synchronous, write-first read.
// The read port is registered and samples the address on every clock, so
// the caller decides when the registered word is meaningful.
module dmem_resp_ram #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic [XLEN-1:0]      rdata_o
);

  logic [XLEN-1:0] mem_q [2**ADDR_BITS];

  // Write-first storage: a write also forwards its data to the read register.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the strobe/done data-memory protocol.
// One request per strobe is served from a local RAM after a fixed number
// of wait states; completion is a one-cycle done pulse with read data.
// Optional build macro DMEM_RESP_STATS_EN adds rd_cnt_o / wr_cnt_o
// counters of completed in-range reads and writes.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter int              ADDR_BITS  = DEF_ADDR_BITS,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter int              RD_LATENCY = DEF_RD_LATENCY,
  parameter int              WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            S_DMEM_strobe_i,
  input  logic [XLEN-1:0] S_DMEM_addr_i,
  input  logic            S_DMEM_rw_i,
  input  logic [XLEN-1:0] S_DMEM_data_i,
  output logic            S_DMEM_done_o,
  output logic [XLEN-1:0] S_DMEM_data_o,
  output logic            range_err_o,
  output logic            proto_err_o
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]     rd_cnt_o,
  output logic [31:0]     wr_cnt_o
`endif
);

  localparam int CW = cnt_width(RD_LATENCY, WR_LATENCY);
  localparam logic [CW-1:0] RD_CNT_INIT = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] WR_CNT_INIT = CW'(WR_LATENCY - 1);

  // The window bounds are one bit wider than the bus so that a window
  // touching the top of the address space cannot wrap back to zero.
  localparam logic [XLEN:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [XLEN:0] WIN_SIZE = (XLEN+1)'(1) << (ADDR_BITS + 2);
  localparam logic [XLEN:0] WIN_HI   = WIN_LO + WIN_SIZE;

  function automatic logic addr_in_range(input logic [XLEN-1:0] a);
    logic [XLEN:0] ax;
    ax = {1'b0, a};
    return (ax >= WIN_LO) && (ax < WIN_HI);
  endfunction

  function automatic logic [ADDR_BITS-1:0] word_index(input logic [XLEN-1:0] a);
    return ADDR_BITS'((a - BASE_ADDR) >> 2);
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            range_err_q, range_err_d;
  logic            proto_err_q, proto_err_d;

  logic                 req_in_range;
  logic [ADDR_BITS-1:0] req_idx;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [XLEN-1:0]      ram_rdata;
  logic [XLEN-1:0]      rd_value;

  // Decode the captured request and steer the RAM so that its registered
  // read lands exactly on the edge that enters DONE.
  always_comb begin
    req_in_range = addr_in_range(addr_q);
    req_idx      = word_index(addr_q);
    ram_addr     = (state_q == IDLE) ? word_index(S_DMEM_addr_i) : req_idx;
    ram_we       = (state_q == DONE) && rw_q && req_in_range;
    rd_value     = req_in_range ? ram_rdata : '0;
  end

  dmem_resp_ram #(
    .XLEN      (XLEN),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Next-state logic: capture in IDLE, count wait states in BUSY, retire in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    range_err_d = range_err_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (S_DMEM_strobe_i) begin
          addr_d  = S_DMEM_addr_i;
          rw_d    = S_DMEM_rw_i;
          wdata_d = S_DMEM_data_i;
          if (!addr_in_range(S_DMEM_addr_i)) begin
            range_err_d = 1'b1;
          end
          if (S_DMEM_rw_i) begin
            cnt_d   = WR_CNT_INIT;
            state_d = (WR_LATENCY == 1) ? DONE : BUSY;
          end else begin
            cnt_d   = RD_CNT_INIT;
            state_d = (RD_LATENCY == 1) ? DONE : BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
        if (S_DMEM_strobe_i) begin
          proto_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!rw_q) begin
          data_d = rd_value;
        end
        if (S_DMEM_strobe_i) begin
          proto_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any in-flight request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      data_q      <= '0;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      range_err_q <= range_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // In the DONE cycle of a read the fresh RAM word is shown directly;
  // otherwise the last completed read is held.
  always_comb begin
    S_DMEM_done_o = (state_q == DONE);
    S_DMEM_data_o = ((state_q == DONE) && !rw_q) ? rd_value : data_q;
    range_err_o   = range_err_q;
    proto_err_o   = proto_err_q;
  end

`ifdef DMEM_RESP_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Count completed in-range accesses; out-of-window ones are not counted.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((state_q == DONE) && req_in_range) begin
      if (rw_q) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers, free-running and wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder
// against a transaction-level memory model kept in the bench.
module tb_dmem_responder;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 4096;

  logic        clk;
  logic        rst;
  logic        strobe;
  logic [31:0] addr_i;
  logic        rw_i;
  logic [31:0] data_i;
  logic        done_o;
  logic [31:0] data_o;
  logic        range_err;
  logic        proto_err;
`ifdef DMEM_RESP_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  dmem_responder #(
    .XLEN       (32),
    .ADDR_BITS  (12),
    .BASE_ADDR  (32'h0000_0000),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .S_DMEM_strobe_i (strobe),
    .S_DMEM_addr_i   (addr_i),
    .S_DMEM_rw_i     (rw_i),
    .S_DMEM_data_i   (data_i),
    .S_DMEM_done_o   (done_o),
    .S_DMEM_data_o   (data_o),
    .range_err_o     (range_err),
    .proto_err_o     (proto_err)
`ifdef DMEM_RESP_STATS_EN
    ,
    .rd_cnt_o        (rd_cnt),
    .wr_cnt_o        (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding transaction, identified by the edge
  // count at which it retires; memory is a sparse word array.
  int unsigned edge_n = 0;
  bit          pend = 0;
  bit          pend_rw = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_wdata = '0;
  int unsigned pend_end = 0;
  logic        exp_done = 0;
  logic [31:0] exp_data = '0;
  bit          exp_known = 1;
  logic        exp_range = 0;
  logic        exp_proto = 0;
  logic [31:0] exp_rd = '0;
  logic [31:0] exp_wr = '0;
  logic [31:0] mem_m [int];

  function automatic bit in_win(input logic [31:0] a);
    return {1'b0, a} < 33'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      = 0;
      exp_done  = 0;
      exp_data  = '0;
      exp_known = 1;
      exp_range = 0;
      exp_proto = 0;
      exp_rd    = '0;
      exp_wr    = '0;
      edge_n    = 0;
    end else begin
      bit busy;
      edge_n = edge_n + 1;
      busy = pend;
      if (pend && edge_n == pend_end) begin
        if (in_win(pend_addr)) begin
          if (pend_rw) begin
            mem_m[widx(pend_addr)] = pend_wdata;
            exp_wr = exp_wr + 1;
          end else begin
            exp_rd = exp_rd + 1;
          end
        end
        pend = 0;
      end
      if (strobe) begin
        if (busy) begin
          exp_proto = 1;
        end else begin
          pend       = 1;
          pend_rw    = rw_i;
          pend_addr  = addr_i;
          pend_wdata = data_i;
          pend_end   = edge_n + (rw_i ? WR_LAT : RD_LAT);
          if (!in_win(addr_i)) exp_range = 1;
        end
      end
      exp_done = pend && (edge_n == pend_end - 1);
      if (exp_done && !pend_rw) begin
        if (!in_win(pend_addr)) begin
          exp_data  = '0;
          exp_known = 1;
        end else if (mem_m.exists(widx(pend_addr))) begin
          exp_data  = mem_m[widx(pend_addr)];
          exp_known = 1;
        end else begin
          exp_known = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("done", 32'(done_o), 32'(exp_done));
      checkOutput("range_err", 32'(range_err), 32'(exp_range));
      checkOutput("proto_err", 32'(proto_err), 32'(exp_proto));
      if (exp_known) checkOutput("data", data_o, exp_data);
`ifdef DMEM_RESP_STATS_EN
      checkOutput("rd_cnt", rd_cnt, exp_rd);
      checkOutput("wr_cnt", wr_cnt, exp_wr);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle strobe, then scramble the request inputs.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    strobe = 1'b1;
    rw_i   = rw;
    addr_i = addr;
    data_i = data;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    rw_i   = 1'($urandom);
    addr_i = $urandom;
    data_i = $urandom;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    strobe = 1'b0;
    rw_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1;
    idle(1);

    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_data", data_o, 32'd0);
    checkOutput("rst_range", 32'(range_err), 32'd0);
    checkOutput("rst_proto", 32'(proto_err), 32'd0);

    // Write then read back with exact latency checks.
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("wr_done_n1", 32'(done_o), 32'd1);
    checkOutput("wr_range", 32'(range_err), 32'd0);
    idle(1);
    checkOutput("wr_done_single", 32'(done_o), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0);
    checkOutput("rd_not_early", 32'(done_o), 32'd0);
    idle(1);
    checkOutput("rd_done_n2", 32'(done_o), 32'd1);
    checkOutput("rd_data", data_o, 32'hDEAD_BEEF);
    idle(1);
    applyStimulus(1'b1, 32'h14, 32'h1);
    idle(1);
    checkOutput("rd_data_hold", data_o, 32'hDEAD_BEEF);

    // Strobe while busy is dropped and flagged.
    applyStimulus(1'b0, 32'h14, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'h0BAD_0BAD);
    checkOutput("proto_done", 32'(done_o), 32'd1);
    checkOutput("proto_data", data_o, 32'h1);
    checkOutput("proto_flag", 32'(proto_err), 32'd1);
    idle(1);
    applyStimulus(1'b0, 32'h10, 32'h0);
    idle(1);
    checkOutput("proto_dropped", data_o, 32'hDEAD_BEEF);
    idle(1);

    // Out-of-window accesses.
    applyStimulus(1'b1, 32'h0, 32'hA5A5_0000);
    idle(1);
    applyStimulus(1'b1, 32'h3FFC, 32'h1357_2468);
    idle(1);
    applyStimulus(1'b0, 32'h4000, 32'h0);
    idle(1);
    checkOutput("oor_done", 32'(done_o), 32'd1);
    checkOutput("oor_data", data_o, 32'h0);
    checkOutput("oor_range", 32'(range_err), 32'd1);
    idle(1);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D);
    idle(1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    idle(1);
    checkOutput("no_wrap_w0", data_o, 32'hA5A5_0000);
    idle(1);
    applyStimulus(1'b0, 32'h3FFC, 32'h0);
    idle(1);
    checkOutput("no_wrap_top", data_o, 32'h1357_2468);
    idle(1);

    // Randomized traffic over a small word pool plus out-of-window hits.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), $urandom);
      idle(1);
    end
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = 32'h4000 + 32'(4 * $urandom_range(0, 255));
        1:       a = 32'hFFFF_FF00 + 32'(4 * $urandom_range(0, 63));
        default: a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      endcase
      applyStimulus(1'($urandom), a, $urandom);
      idle($urandom_range(0, 3));
    end
    idle(5);

    // Asynchronous reset during the completion of a write.
    applyStimulus(1'b1, 32'h20, 32'h77);
    idle(1);
    applyStimulus(1'b1, 32'h20, 32'h55);
    checkOutput("pre_rst_done", 32'(done_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_done", 32'(done_o), 32'd0);
    checkOutput("rst_async_proto", 32'(proto_err), 32'd0);
    #1 rst = 1'b0;
    idle(1);
    applyStimulus(1'b0, 32'h20, 32'h0);
    idle(1);
    checkOutput("rst_write_lost", data_o, 32'h77);
    idle(1);

    // Three in-range reads, two writes and one out-of-window read.
    applyStimulus(1'b0, 32'h10, 32'h0);
    idle(2);
    applyStimulus(1'b0, 32'h0, 32'h0);
    idle(2);
    applyStimulus(1'b1, 32'h24, 32'h2424_2424);
    idle(1);
    applyStimulus(1'b1, 32'h28, 32'h2828_2828);
    idle(1);
    applyStimulus(1'b0, 32'h4000, 32'h0);
    idle(2);
    checkOutput("oor_after_rst", 32'(range_err), 32'd1);
`ifdef DMEM_RESP_STATS_EN
    checkOutput("stats_rd", rd_cnt, 32'd3);
    checkOutput("stats_wr", wr_cnt, 32'd2);
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
